// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
// State encoding, round-robin pick function and sizing limits.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      LOCKED
   } arb_state_e;

   localparam int MAX_RD_LAT = 4;
   localparam int MAX_REQ    = 8;
   localparam int IDX_W      = $clog2(MAX_REQ);

   // One-hot of the first set valid bit at or after ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0] valid,
      input int                 n,
      input int                 ptr
   );
      logic [MAX_REQ-1:0] oh;
      logic               found;
      int                 idx;
      oh    = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (k < n && !found && valid[IDX_W'(idx)]) begin
            oh[IDX_W'(idx)] = 1'b1;
            found           = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// One-hot requester-ID delay line for in-flight reads.
// The last stage is the response-valid strobe.
module mem_arb_rsp_pipe
   import mem_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] id,
   output logic [N-1:0] rsp_valid,
   output logic         busy
);

   logic [N-1:0] stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else begin
         stage_q[0] <= load ? id : '0;
         for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < DEPTH; k++) busy = busy | (|stage_q[k]);
   end

   assign rsp_valid = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory macro.
// Define MEM_ARB_LOCK_EN to add the req_lock bus-locking input.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int RD_LAT  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
`ifdef MEM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        req_lock,
`endif
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ ||
       RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_cfg
      $error("mem_port_arbiter: parameter out of range");
   end

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               mem_en_q, mem_we_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [DATA_W-1:0]  mem_wdata_q;
   logic [MAX_REQ-1:0] valid_ext, grant_w;
   logic               hs, busy, pipe_busy;
   logic               win_we, win_lock;
   logic [IDX_W-1:0]   win_idx, win_nxt;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_wdata;
`ifdef MEM_ARB_LOCK_EN
   logic [IDX_W-1:0]   owner_q, owner_d;
`endif

   always_comb begin
      valid_ext                = '0;
      valid_ext[NUM_REQ-1:0]   = req_valid;
      grant_w = rr_pick(valid_ext, NUM_REQ, int'(ptr_q));
`ifdef MEM_ARB_LOCK_EN
      // A locked owner excludes everyone else, even when it idles.
      if (state_q == LOCKED) begin
         grant_w          = '0;
         grant_w[owner_q] = valid_ext[owner_q];
      end
`endif
      if (rst) grant_w = '0;
      hs = |grant_w;
   end

   always_comb begin
      win_we    = 1'b0;
      win_lock  = 1'b0;
      win_idx   = '0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_w[i]) begin
            win_idx   = IDX_W'(i);
            win_we    = req_we[i];
            win_addr  = req_addr[i*ADDR_W +: ADDR_W];
            win_wdata = req_wdata[i*DATA_W +: DATA_W];
`ifdef MEM_ARB_LOCK_EN
            win_lock  = req_lock[i];
`endif
         end
      end
      win_nxt = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
   end

   assign busy = mem_en_q | pipe_busy;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
`ifdef MEM_ARB_LOCK_EN
      owner_d = owner_q;
      if (hs && win_lock) owner_d = win_idx;
`endif
      // The pointer stays parked while a lock is being held.
      if (hs && !win_lock) ptr_d = win_nxt;
      unique case (state_q)
         LOCKED: begin
            if (hs && !win_lock) state_d = ACTIVE;
         end
         default: begin
            if (hs && win_lock)  state_d = LOCKED;
            else if (hs || busy) state_d = ACTIVE;
            else                 state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         mem_en_q <= hs;
         if (hs) begin
            mem_we_q    <= win_we;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
         end
      end
   end

`ifdef MEM_ARB_LOCK_EN
   always_ff @(posedge clk) begin
      if (rst) owner_q <= '0;
      else     owner_q <= owner_d;
   end
`endif

   mem_arb_rsp_pipe #(
      .N     (NUM_REQ),
      .DEPTH (RD_LAT + 1)
   ) u_rsp_pipe (
      .clk       (clk),
      .rst       (rst),
      .load      (hs && !win_we),
      .id        (grant_w[NUM_REQ-1:0]),
      .rsp_valid (rsp_valid),
      .busy      (pipe_busy)
   );

   assign req_ready = grant_w[NUM_REQ-1:0];
   assign rsp_rdata = (|rsp_valid) ? mem_rdata : '0;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (2 requesters, RD_LAT=2).
// Lock vectors run only when MEM_ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;

   localparam int N  = 2;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int RL = 2;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            cyc;
   } cmd_t;

   typedef struct {
      logic [N-1:0]  id;
      logic [DW-1:0] data;
      int            cyc;
   } rsp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
   logic            mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
`ifdef MEM_ARB_LOCK_EN
   logic [N-1:0]    req_lock;
`endif

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(
      .NUM_REQ (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .RD_LAT  (RL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
`ifdef MEM_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Macro model: unwritten words read as 0x1000_0000 + address.
   logic [DW-1:0] mem [256];
   logic [255:0]  wr_mask = '0;
   logic [DW-1:0] rd1 = '0, rd2 = '0;
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem[mem_addr]     <= mem_wdata;
         wr_mask[mem_addr] <= 1'b1;
      end
      if (mem_en && !mem_we)
         rd1 <= wr_mask[mem_addr] ? mem[mem_addr]
                                  : 32'h1000_0000 + DW'(mem_addr);
      else
         rd1 <= '0;
      rd2 <= rd1;
   end
   assign mem_rdata = rd2;

   always begin
      @(negedge clk);
      if (mem_en) begin
         n_vec++;
         if (cmd_q.size() == 0) begin
            n_miss++;
            $display("FAIL cmd_extra: got en at cyc %0d, required none",
                     cyc);
         end else begin
            cmd_t c;
            c = cmd_q.pop_front();
            if (mem_we !== c.we || mem_addr !== c.addr ||
                mem_wdata !== c.wdata || cyc != c.cyc) begin
               n_miss++;
               $display("FAIL cmd: got we=%b a=%h d=%h cyc=%0d, required we=%b a=%h d=%h cyc=%0d",
                        mem_we, mem_addr, mem_wdata, cyc,
                        c.we, c.addr, c.wdata, c.cyc);
            end
         end
      end
      n_vec++;
      if (rsp_valid !== '0) begin
         if (rsp_q.size() == 0) begin
            n_miss++;
            $display("FAIL rsp_extra: got valid=%b at cyc %0d, required none",
                     rsp_valid, cyc);
         end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            if (rsp_valid !== r.id || rsp_rdata !== r.data ||
                cyc != r.cyc) begin
               n_miss++;
               $display("FAIL rsp: got id=%b d=%h cyc=%0d, required id=%b d=%h cyc=%0d",
                        rsp_valid, rsp_rdata, cyc, r.id, r.data, r.cyc);
            end
         end
      end else if (rsp_rdata !== '0) begin
         n_miss++;
         $display("FAIL rdata_idle: got %h, required 0", rsp_rdata);
      end
   end

   task automatic step(
      input logic          r,
      input logic [N-1:0]  v,
      input logic [N-1:0]  we,
      input logic [AW-1:0] a0,
      input logic [AW-1:0] a1,
      input logic [DW-1:0] d0,
      input logic [DW-1:0] d1,
      input logic [N-1:0]  exp_rdy,
      input logic [DW-1:0] exp_rd
   );
      cmd_t c;
      rsp_t s;
      int   i;
      @(negedge clk);
      rst       = r;
      req_valid = v;
      req_we    = we;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
      #1;
      n_vec++;
      if (req_ready !== exp_rdy) begin
         n_miss++;
         $display("FAIL ready: cyc %0d got %b, required %b",
                  cyc, req_ready, exp_rdy);
      end
      if (exp_rdy != '0) begin
         i       = exp_rdy[1] ? 1 : 0;
         c.we    = we[i];
         c.addr  = i ? a1 : a0;
         c.wdata = i ? d1 : d0;
         c.cyc   = cyc + 1;
         cmd_q.push_back(c);
         if (!we[i]) begin
            s.id   = exp_rdy;
            s.data = exp_rd;
            s.cyc  = cyc + RL + 1;
            rsp_q.push_back(s);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 2'b00, 2'b00, 8'h0, 8'h0, 0, 0, 2'b00, 0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
      req_lock  = '0;
`endif
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 2'b11, 2'b00, 8'h10, 8'h20, 0, 0, 2'b00, 0);
         n_vec++;
         if (mem_en !== 1'b0 || rsp_valid !== '0) begin
            n_miss++;
            $display("FAIL reset_out: en=%b rv=%b, required 0 0",
                     mem_en, rsp_valid);
         end
      end

      // Fairness: both requesters reading continuously.
      step(0, 2'b11, 2'b00, 8'h10, 8'h20, 32'hA0, 32'hA1,
           2'b01, 32'h1000_0010);
      step(0, 2'b11, 2'b00, 8'h10, 8'h20, 32'hA0, 32'hA1,
           2'b10, 32'h1000_0020);
      step(0, 2'b11, 2'b00, 8'h10, 8'h20, 32'hA0, 32'hA1,
           2'b01, 32'h1000_0010);
      step(0, 2'b11, 2'b00, 8'h10, 8'h20, 32'hA0, 32'hA1,
           2'b10, 32'h1000_0020);
      idle(1);

      // Write then read the same word in back-to-back cycles.
      step(0, 2'b10, 2'b10, 8'h00, 8'h05, 0, 32'hDEAD_BEEF,
           2'b10, 0);
      step(0, 2'b01, 2'b00, 8'h05, 8'h00, 32'h55, 0,
           2'b01, 32'hDEAD_BEEF);

      // req1 alone three times; pointer wraps back to req0.
      step(0, 2'b10, 2'b00, 8'h00, 8'h30, 0, 0, 2'b10, 32'h1000_0030);
      step(0, 2'b10, 2'b00, 8'h00, 8'h31, 0, 0, 2'b10, 32'h1000_0031);
      step(0, 2'b10, 2'b00, 8'h00, 8'h32, 0, 0, 2'b10, 32'h1000_0032);
      step(0, 2'b11, 2'b00, 8'h40, 8'h41, 0, 0, 2'b01, 32'h1000_0040);
      step(0, 2'b00, 2'b00, 8'h40, 8'h41, 0, 0, 2'b00, 0);
      step(0, 2'b11, 2'b00, 8'h40, 8'h41, 0, 0, 2'b10, 32'h1000_0041);
      step(0, 2'b00, 2'b00, 8'h40, 8'h41, 0, 0, 2'b00, 0);
      step(0, 2'b11, 2'b00, 8'h40, 8'h41, 0, 0, 2'b01, 32'h1000_0040);
      idle(5);

      // Read issued, then reset: the command goes out, no response.
      step(0, 2'b01, 2'b00, 8'h50, 8'h00, 0, 0, 2'b01, 32'h1000_0050);
      void'(rsp_q.pop_back());
      step(1, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0);
      idle(5);
      step(0, 2'b11, 2'b00, 8'h60, 8'h61, 0, 0, 2'b01, 32'h1000_0060);
      idle(4);

`ifdef MEM_ARB_LOCK_EN
      // Pointer now sits at req1; req0 locks and holds the port.
      req_lock = 2'b01;
      step(0, 2'b01, 2'b01, 8'h70, 8'h0, 32'hC0DE_0070, 0, 2'b01, 0);
      step(0, 2'b11, 2'b01, 8'h71, 8'h0, 32'hC0DE_0071, 0, 2'b01, 0);
      step(0, 2'b10, 2'b00, 8'h00, 8'h0, 0, 0, 2'b00, 0);
      step(0, 2'b11, 2'b01, 8'h72, 8'h0, 32'hC0DE_0072, 0, 2'b01, 0);
      step(0, 2'b11, 2'b01, 8'h73, 8'h0, 32'hC0DE_0073, 0, 2'b01, 0);
      req_lock = 2'b00;
      step(0, 2'b11, 2'b00, 8'h70, 8'h7F, 0, 0, 2'b01, 32'hC0DE_0070);
      step(0, 2'b11, 2'b00, 8'h70, 8'h7F, 0, 0, 2'b10, 32'h1000_007F);
`endif

      idle(8);
      n_vec++;
      if (cmd_q.size() != 0 || rsp_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d cmd %0d rsp pending, required 0 0",
                  cmd_q.size(), rsp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory macro (MEM-style: one address/enable, one read-data return) between NUM_REQ requesters.
- Round-robin grant, one access per cycle, with per-requester valid/ready handshake.
- Tracks in-flight reads and routes read data back to the issuing requester after a fixed macro latency.
- Sits between requester logic and the MEM macro; it is the macro's only driver.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, memory address width.
- DATA_W, 32, memory data width.
- RD_LAT, 1, cycles from mem_en (read) to mem_rdata valid (1..4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  one-hot read-data valid, one cycle.
- rsp_rdata  out  DATA_W  read data, shared by all requesters, qualified by rsp_valid.
- mem_en  out  1  macro access enable.
- mem_we  out  1  macro write enable.
- mem_addr  out  ADDR_W  macro address.
- mem_wdata  out  DATA_W  macro write data.
- mem_rdata  in  DATA_W  macro read data, valid RD_LAT cycles after a read mem_en.

Behaviour:
- Reset: all outputs 0; rr pointer = 0; in-flight pipeline cleared; FSM = IDLE.
- Grant selection (combinational from registered state):
  - Search starts at index ptr and wraps modulo NUM_REQ.
  - First asserted req_valid wins.
  - req_ready is asserted only for the winner. No grant when no valid or while in rst.
- Memory command is registered:
  - The cycle after a handshake, mem_en=1, with mem_we/addr/wdata = the winner's fields.
  - Otherwise mem_en=0, and mem_we/addr/wdata hold their last value.
- Pointer:
  - On each handshake, ptr <= winner+1 (wraps NUM_REQ-1 -> 0).
  - With no handshake, ptr holds.
- Read tracking:
  - A one-hot ID shift register of depth RD_LAT+1 is loaded on each read handshake.
  - rsp_valid[i] pulses RD_LAT+1 cycles after the handshake cycle (1 for the mem_en register stage + RD_LAT).
  - rsp_rdata = mem_rdata in that cycle, otherwise 0.
  - Writes produce no response.
- Throughput: back-to-back handshakes every cycle. There is no response backpressure; requesters must accept rsp_valid.
- FSM:
  - IDLE: no outstanding access.
  - ACTIVE: at least one command or read in flight.
  - IDLE->ACTIVE on a handshake. ACTIVE->IDLE when the pipeline is empty and there is no handshake.
  - The FSM is informational only (drives no port) and exists for assertions and the lock feature.
- Boundaries:
  - All requesters valid every cycle: grants rotate 0,1,..,N-1,0 strictly.
  - A requester dropping valid before ready: no grant, ptr unchanged.
  - Reset mid-read: the in-flight response is dropped, with no rsp_valid after reset.
  - Write then read to the same address in consecutive cycles: the macro sees them in order, so the read returns the new data.

Optional Feature:
- Macro MEM_ARB_LOCK_EN adds input req_lock (NUM_REQ).
- With it: if the granted requester has req_lock=1 on a handshake, FSM enters LOCKED.
  - In LOCKED only that requester can be granted and ptr does not advance.
  - LOCKED exits on a handshake with req_lock=0, then ptr = owner+1.
  - LOCKED with owner valid=0 grants nobody.
- Without it: no req_lock port, no LOCKED state, pure round-robin.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACTIVE, LOCKED);
  - function for round-robin pick (onehot from valid and ptr);
  - localparam max RD_LAT.
- One sub-module, mem_arb_rsp_pipe: parameterized one-hot ID shift register producing rsp_valid.

Test Plan:
- Reset: assert rst 3 cycles with all req_valid=1 -> req_ready=0, mem_en=0, rsp_valid=0; first grant goes to requester 0 the cycle after rst drops.
- Fairness: NUM_REQ=2, both continuously read addr 0x10/0x20 -> grants alternate 0,1,0,1; mem_addr alternates 0x10,0x20 one cycle later.
- Read return: RD_LAT=2, write 0xDEADBEEF to 0x05 from req1, then read 0x05 from req0 -> rsp_valid[0] pulses exactly 3 cycles after the read handshake, with rsp_rdata=0xDEADBEEF and rsp_valid[1] never set.
- Idle pointer: req1 alone issues 3 reads, then req0 and req1 both valid -> req0 granted first (ptr wrapped to 0).
- Reset mid-flight: read handshake, rst asserted the next cycle -> no rsp_valid in the following 5 cycles.
- Lock (MEM_ARB_LOCK_EN): req0 issues 4 locked accesses while req1 valid -> req1 stalled throughout; after req0's unlocked access, req1 granted next.
